// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared definitions for the MIPS multi-cycle control path.
// Holds the main FSM state encoding, opcode constants, ALUOp/ALUSrcB/PCSrc
// encodings, the control-word payload and an opcode classifier.
// Optional feature macro: MAIN_CTRL_ADDI_EN (addi support in the classifier).
package mips_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    // 4-bit binary state encoding; 13..15 are unused.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pcsrc_t;

    typedef enum logic [2:0] {
        OPC_MEM,
        OPC_RTYPE,
        OPC_BEQ,
        OPC_ADDI,
        OPC_J,
        OPC_ILLEGAL
    } op_class_t;

    // Control word driven by the state decoder.
    typedef struct packed {
        logic   ir_write;
        logic   pc_write;
        logic   branch;
        logic   i_or_d;
        logic   mem_write;
        logic   mem_to_reg;
        logic   reg_dst;
        logic   reg_write;
        logic   alu_src_a;
        srcb_t  alu_src_b;
        aluop_t alu_op;
        pcsrc_t pc_src;
        logic   instr_done;
    } ctrl_word_t;

    // Classify an opcode into the instruction flow it follows.
    function automatic op_class_t decode_op(input logic [OP_W-1:0] op);
        op_class_t c;
        c = OPC_ILLEGAL;
        case (op)
            OP_LW, OP_SW: c = OPC_MEM;
            OP_RTYPE:     c = OPC_RTYPE;
            OP_BEQ:       c = OPC_BEQ;
`ifdef MAIN_CTRL_ADDI_EN
            OP_ADDI:      c = OPC_ADDI;
`endif
            OP_J:         c = OPC_J;
            default:      c = OPC_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/main_ctrl_out_dec.sv
// main_ctrl_out_dec: combinational state -> control-word decode (Moore outputs).
// Ports: state (in, current FSM state), ctrl (out, datapath control word).
// Optional feature macro: MAIN_CTRL_ADDI_EN (ADDIEX/ADDIWB decode present).
module main_ctrl_out_dec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    // Everything defaults to 0; IDLE and unused encodings fall through.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.i_or_d = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MAIN_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            S_JUMP: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle MIPS main control unit (Moore FSM).
// Sequences FETCH/DECODE/execute/memory/write-back and drives all datapath
// enables and selects; Illegal_Op is the only Opcode-dependent output and is
// asserted only in DECODE.
// Ports: CLK, RST (async active-low), Opcode (IR[31:26]); outputs IRWrite,
// PCWrite, Branch, IorD, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
// ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], Illegal_Op, Instr_Done.
// Optional feature macro: MAIN_CTRL_ADDI_EN (addi via ADDIEX/ADDIWB).
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_WIDTH = 6
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [OPCODE_WIDTH-1:0] Opcode,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    Branch,
    output logic                    IorD,
    output logic                    MemWrite,
    output logic                    MemtoReg,
    output logic                    RegDst,
    output logic                    RegWrite,
    output logic                    ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ALUOp,
    output logic [1:0]              PCSrc,
    output logic                    Illegal_Op,
    output logic                    Instr_Done
);

    state_t     state_q, state_d;
    logic       is_store_q, is_store_d;
    logic       illegal_op_c;
    logic [OP_W-1:0] op6;
    op_class_t  op_class;
    ctrl_word_t ctrl;

    assign op6      = OP_W'(Opcode);
    assign op_class = decode_op(op6);

    // State register and load/store flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    // Next-state logic; Opcode is only consulted in DECODE.
    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        illegal_op_c = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                is_store_d = (op6 == OP_SW);
                case (op_class)
                    OPC_MEM:   state_d = S_MEMADR;
                    OPC_RTYPE: state_d = S_EXECUTE;
                    OPC_BEQ:   state_d = S_BRANCH;
`ifdef MAIN_CTRL_ADDI_EN
                    OPC_ADDI:  state_d = S_ADDIEX;
`endif
                    OPC_J:     state_d = S_JUMP;
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
`ifdef MAIN_CTRL_ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`endif
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            // Unused encodings recover to FETCH.
            default:   state_d = S_FETCH;
        endcase
    end

    main_ctrl_out_dec u_out_dec (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign IRWrite    = ctrl.ir_write;
    assign PCWrite    = ctrl.pc_write;
    assign Branch     = ctrl.branch;
    assign IorD       = ctrl.i_or_d;
    assign MemWrite   = ctrl.mem_write;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegDst     = ctrl.reg_dst;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign PCSrc      = ctrl.pc_src;
    assign Instr_Done = ctrl.instr_done;
    assign Illegal_Op = illegal_op_c;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: self-checking bench for main_control_fsm.
// Expected per-cycle control vectors come from an instruction-level table
// of what each opcode must produce cycle by cycle after FETCH.
module tb_main_control_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] Opcode;
    logic IRWrite, PCWrite, Branch, IorD, MemWrite, MemtoReg, RegDst;
    logic RegWrite, ALUSrcA, Illegal_Op, Instr_Done;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    main_control_fsm #(.OPCODE_WIDTH(6)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .Illegal_Op(Illegal_Op),
        .Instr_Done(Instr_Done)
    );

    // Vector layout: IRW PCW BR IORD MW M2R RD RW SA SB[2] AOP[2] PCS[2] ILL DONE
    localparam logic [16:0] IRW  = 17'h10000;
    localparam logic [16:0] PCW  = 17'h08000;
    localparam logic [16:0] BR   = 17'h04000;
    localparam logic [16:0] IORD = 17'h02000;
    localparam logic [16:0] MW   = 17'h01000;
    localparam logic [16:0] M2R  = 17'h00800;
    localparam logic [16:0] RD   = 17'h00400;
    localparam logic [16:0] RW   = 17'h00200;
    localparam logic [16:0] SA   = 17'h00100;
    localparam logic [16:0] ILL  = 17'h00002;
    localparam logic [16:0] DONE = 17'h00001;

    function automatic logic [16:0] sb(input int x);  return 17'(x) << 6; endfunction
    function automatic logic [16:0] aop(input int x); return 17'(x) << 4; endfunction
    function automatic logic [16:0] pcs(input int x); return 17'(x) << 2; endfunction

    function automatic logic [16:0] obs();
        return {IRWrite, PCWrite, Branch, IorD, MemWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, Illegal_Op, Instr_Done};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp);
        logic [16:0] o;
        o = obs();
        total++;
        assert (o === exp) else begin
            bad++;
            $error("FAIL %s observed=%05h expected=%05h", tag, o, exp);
        end
    endtask

    logic [16:0] exp_q[$];

    // Expected cycle-by-cycle outputs of one instruction, FETCH first.
    task automatic fill(input logic [5:0] op);
        bit addi_en;
`ifdef MAIN_CTRL_ADDI_EN
        addi_en = 1'b1;
`else
        addi_en = 1'b0;
`endif
        exp_q.delete();
        exp_q.push_back(IRW | PCW | sb(1) | aop(0));
        if (op == 6'b100011) begin            // lw
            exp_q.push_back(sb(3));
            exp_q.push_back(SA | sb(2));
            exp_q.push_back(IORD);
            exp_q.push_back(RW | M2R | DONE);
        end else if (op == 6'b101011) begin   // sw
            exp_q.push_back(sb(3));
            exp_q.push_back(SA | sb(2));
            exp_q.push_back(IORD | MW | DONE);
        end else if (op == 6'b000000) begin   // R-type
            exp_q.push_back(sb(3));
            exp_q.push_back(SA | sb(0) | aop(2));
            exp_q.push_back(RW | RD | DONE);
        end else if (op == 6'b000100) begin   // beq
            exp_q.push_back(sb(3));
            exp_q.push_back(SA | aop(1) | pcs(1) | BR | DONE);
        end else if (op == 6'b001000 && addi_en) begin
            exp_q.push_back(sb(3));
            exp_q.push_back(SA | sb(2));
            exp_q.push_back(RW | DONE);
        end else if (op == 6'b000010) begin   // j
            exp_q.push_back(sb(3));
            exp_q.push_back(pcs(2) | PCW | DONE);
        end else begin                         // illegal
            exp_q.push_back(sb(3) | ILL);
        end
    endtask

    // Run one instruction; Opcode is scrambled outside DECODE. max_cyc=0 runs all.
    task automatic run_instr(input logic [5:0] op, input int max_cyc);
        int n;
        fill(op);
        n = (max_cyc == 0) ? exp_q.size() : max_cyc;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            Opcode = (i == 1) ? op : 6'($urandom);
            #1;
            chk($sformatf("op%06b_c%0d", op, i + 1), exp_q[i]);
        end
    endtask

    logic [5:0] legal_ops[6];

    initial begin
        legal_ops[0] = 6'b100011; legal_ops[1] = 6'b101011;
        legal_ops[2] = 6'b000000; legal_ops[3] = 6'b000100;
        legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;

        RST    = 1'b0;
        Opcode = 6'b111111;
        #1;
        chk("reset_async", 17'h0);
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk("reset_hold", 17'h0);
        end
        #2;
        RST = 1'b1;
        #1;
        chk("idle_after_release", 17'h0);

        // Directed: lw, sw then R-type back-to-back, beq, illegal, addi.
        run_instr(6'b100011, 0);
        run_instr(6'b101011, 0);
        run_instr(6'b000000, 0);
        run_instr(6'b000100, 0);
        run_instr(6'b111111, 0);
        run_instr(6'b001000, 0);
        run_instr(6'b000010, 0);

        // Reset during MEMRD of a lw: outputs drop immediately, no RegWrite.
        run_instr(6'b100011, 4);
        #1;
        RST = 1'b0;
        #1;
        chk("abort_async", 17'h0);
        repeat (2) begin
            @(negedge CLK);
            #1;
            chk("abort_hold", 17'h0);
        end
        #2;
        RST = 1'b1;
        #1;
        chk("abort_idle", 17'h0);
        run_instr(6'b101011, 0);

        // Randomized instruction stream.
        repeat (60) begin
            logic [5:0] op;
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            run_instr(op, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
